// File: rtl/satswarmv2_pkg.sv
// Shared types for the SAT swarm host controller: FSM encoding, latched result record
// and the winner-index width helper.
package satswarmv2_pkg;

    localparam int LIT_W = 32;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        SOLVE = 2'd2,
        DONE  = 2'd3
    } swarm_state_e;

    typedef struct packed {
        logic done;
        logic sat;
        logic unsat;
        logic timeout;
    } swarm_result_t;

    // A single core still needs one bit to carry its index.
    function automatic int id_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/swarm_host_ctrl_if.sv
// Host-side CNF stream / control plus the broadcast bus towards the solver cores.
// master = host and cores environment, slave = swarm_host_ctrl.
interface swarm_host_ctrl_if #(
    parameter int NUM_CORES = 4,
    parameter int CNT_W     = 32
);
    import satswarmv2_pkg::*;

    localparam int ID_W = id_w(NUM_CORES);

    logic                    host_load_valid;
    logic signed [LIT_W-1:0] host_load_literal;
    logic                    host_load_clause_end;
    logic                    host_load_ready;

    logic                    host_start;
    logic                    host_abort;
    logic [CNT_W-1:0]        host_timeout_lim;

    logic                    host_done;
    logic                    host_sat;
    logic                    host_unsat;
    logic                    host_timeout;
    logic [ID_W-1:0]         host_winner;
    logic [CNT_W-1:0]        host_cycles;

    logic                    core_load_valid;
    logic signed [LIT_W-1:0] core_load_literal;
    logic                    core_load_clause_end;
    logic [NUM_CORES-1:0]    core_load_ready;

    logic                    core_start;
    logic                    core_abort;
    logic [NUM_CORES-1:0]    core_done;
    logic [NUM_CORES-1:0]    core_sat;
    logic [NUM_CORES-1:0]    core_unsat;

    modport master (
        output host_load_valid, host_load_literal, host_load_clause_end,
        input  host_load_ready,
        output host_start, host_abort, host_timeout_lim,
        input  host_done, host_sat, host_unsat, host_timeout, host_winner, host_cycles,
        input  core_load_valid, core_load_literal, core_load_clause_end,
        output core_load_ready,
        input  core_start, core_abort,
        output core_done, core_sat, core_unsat
    );

    modport slave (
        input  host_load_valid, host_load_literal, host_load_clause_end,
        output host_load_ready,
        input  host_start, host_abort, host_timeout_lim,
        output host_done, host_sat, host_unsat, host_timeout, host_winner, host_cycles,
        output core_load_valid, core_load_literal, core_load_clause_end,
        input  core_load_ready,
        output core_start, core_abort,
        input  core_done, core_sat, core_unsat
    );

endinterface

// File: rtl/swarm_winner_pick.sv
// Lowest-index priority encoder over the valid-finisher vector.
// Purely combinational; no backpressure.
module swarm_winner_pick
    import satswarmv2_pkg::*;
#(
    parameter int NUM_CORES = 4
) (
    input  logic [NUM_CORES-1:0]      vld,
    output logic                      found,
    output logic [id_w(NUM_CORES)-1:0] idx
);
    localparam int ID_W = id_w(NUM_CORES);

    // Scan from the top so the lowest set index is the last one written.
    always_comb begin
        found = 1'b0;
        idx   = '0;
        for (int i = NUM_CORES - 1; i >= 0; i--) begin
            if (vld[i]) begin
                found = 1'b1;
                idx   = ID_W'(i);
            end
        end
    end

endmodule

// File: rtl/swarm_host_ctrl.sv
// Host front-end for the solver swarm: literal broadcast, start/abort, winner/timeout latch.
// Latency: host word -> core bus 1 cycle; finisher/abort/timeout -> host_done 1 cycle.
// Backpressure: one-entry slice retires only when every core is ready; timeout needs SWARM_HOST_TIMEOUT_EN.
module swarm_host_ctrl
    import satswarmv2_pkg::*;
#(
    parameter int NUM_CORES = 4,
    parameter int CNT_W     = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    swarm_host_ctrl_if.slave  bus
);
    localparam int ID_W = id_w(NUM_CORES);

    swarm_state_e            state;
    logic                    start_pend;
    swarm_result_t           res;
    logic [ID_W-1:0]         winner;
    logic [CNT_W-1:0]        cycles;
    logic                    start_q;
    logic                    abort_q;

    logic                    slc_vld;
    logic signed [LIT_W-1:0] slc_lit;
    logic                    slc_end;

    logic                    all_rdy;
    logic                    load_rdy;
    logic                    acc;
    logic                    retire;
    logic                    pend_eff;
    logic                    go_solve;
    logic                    timeout_hit;
    logic [NUM_CORES-1:0]    fin_vld;
    logic                    fin_found;
    logic [ID_W-1:0]         fin_idx;

    assign all_rdy = &bus.core_load_ready;

    // Gated by rst_n so the host never sees ready while the block is held in reset.
    assign load_rdy = rst_n && (!slc_vld || all_rdy) && !start_pend && (state != SOLVE);
    assign acc      = bus.host_load_valid && load_rdy;
    assign retire   = slc_vld && all_rdy;

    // A start request waits until the broadcast slice has fully drained.
    assign pend_eff = (state != SOLVE) && (start_pend || bus.host_start);
    assign go_solve = pend_eff && !slc_vld && !acc;

    assign fin_vld = bus.core_done & (bus.core_sat ^ bus.core_unsat);

    swarm_winner_pick #(
        .NUM_CORES (NUM_CORES)
    ) u_winner_pick (
        .vld   (fin_vld),
        .found (fin_found),
        .idx   (fin_idx)
    );

`ifdef SWARM_HOST_TIMEOUT_EN
    assign timeout_hit = (bus.host_timeout_lim != '0) && (cycles == bus.host_timeout_lim);
    assign bus.host_timeout = res.timeout;
`else
    logic unused_timeout_bits;
    assign unused_timeout_bits = ^{bus.host_timeout_lim, res.timeout};
    assign timeout_hit         = 1'b0;
    assign bus.host_timeout    = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slc_vld <= 1'b0;
            slc_lit <= '0;
            slc_end <= 1'b0;
        end else if (acc) begin
            slc_vld <= 1'b1;
            slc_lit <= bus.host_load_literal;
            slc_end <= bus.host_load_clause_end;
        end else if (retire) begin
            slc_vld <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            start_pend <= 1'b0;
            res        <= '0;
            winner     <= '0;
            cycles     <= '0;
            start_q    <= 1'b0;
            abort_q    <= 1'b0;
        end else begin
            start_q <= 1'b0;
            abort_q <= 1'b0;
            case (state)
                IDLE, LOAD, DONE: begin
                    if (go_solve) begin
                        state      <= SOLVE;
                        start_pend <= 1'b0;
                        start_q    <= 1'b1;
                        res        <= '0;
                        winner     <= '0;
                        cycles     <= '0;
                    end else begin
                        start_pend <= pend_eff;
                        if (bus.host_load_valid && (state != LOAD)) begin
                            state  <= LOAD;
                            res    <= '0;
                            winner <= '0;
                            cycles <= '0;
                        end
                    end
                end
                SOLVE: begin
                    // The terminating cycle is not counted, so a timeout reports exactly the limit.
                    if (fin_found) begin
                        state     <= DONE;
                        abort_q   <= 1'b1;
                        res.done  <= 1'b1;
                        res.sat   <= bus.core_sat[fin_idx];
                        res.unsat <= bus.core_unsat[fin_idx];
                        winner    <= fin_idx;
                    end else if (bus.host_abort) begin
                        state    <= DONE;
                        abort_q  <= 1'b1;
                        res.done <= 1'b1;
                    end else if (timeout_hit) begin
                        state       <= DONE;
                        abort_q     <= 1'b1;
                        res.done    <= 1'b1;
                        res.timeout <= 1'b1;
                    end else if (cycles != '1) begin
                        cycles <= cycles + CNT_W'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.host_load_ready      = load_rdy;
    assign bus.core_load_valid      = slc_vld;
    assign bus.core_load_literal    = slc_lit;
    assign bus.core_load_clause_end = slc_end;
    assign bus.core_start           = start_q;
    assign bus.core_abort           = abort_q;
    assign bus.host_done            = res.done;
    assign bus.host_sat             = res.sat;
    assign bus.host_unsat           = res.unsat;
    assign bus.host_winner          = winner;
    assign bus.host_cycles          = cycles;

endmodule

// File: tb/tb_swarm_host_ctrl.sv
// Bench for swarm_host_ctrl: solve-outcome table, randomized solve rounds against a
// rule-level model, and hand sequences for streaming, delayed start, timeout and reset.
module tb_swarm_host_ctrl;
    localparam int NC = 4;
    localparam int CW = 32;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    swarm_host_ctrl_if #(.NUM_CORES(NC), .CNT_W(CW)) bus ();

    swarm_host_ctrl #(.NUM_CORES(NC), .CNT_W(CW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int checks    = 0;
    int errors    = 0;
    int abort_cnt = 0;
    int start_cnt = 0;
    logic [32:0] delivered[$];

    // Inputs only change just after a rising edge, so the falling edge sees what the next rising edge will.
    always @(negedge clk) begin
        if (bus.core_abort) abort_cnt++;
        if (bus.core_start) start_cnt++;
        if (bus.core_load_valid && (&bus.core_load_ready))
            delivered.push_back({bus.core_load_clause_end, bus.core_load_literal});
    end

    typedef struct {
        logic [3:0] done;
        logic [3:0] sat;
        logic [3:0] unsat;
        logic       abort;
        logic       term;
        logic       e_sat;
        logic       e_unsat;
        logic [1:0] e_win;
    } vec_t;

    vec_t tbl[8];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.host_load_valid      = 1'b0;
        bus.host_load_literal    = '0;
        bus.host_load_clause_end = 1'b0;
        bus.host_start           = 1'b0;
        bus.host_abort           = 1'b0;
        bus.core_load_ready      = 4'hF;
        bus.core_done            = '0;
        bus.core_sat             = '0;
        bus.core_unsat           = '0;
    endtask

    // Outcome of one SOLVE cycle from the rules: any core with exactly one result flag
    // finishes and the lowest such index wins; otherwise a host abort ends the solve.
    function automatic void ref_model(input logic [3:0] d, input logic [3:0] s, input logic [3:0] u,
                                      input logic ab, output logic term, output logic es,
                                      output logic eu, output logic [1:0] w);
        term = 1'b0; es = 1'b0; eu = 1'b0; w = 2'd0;
        for (int i = 0; i < NC; i++) begin
            if (!term && d[i] && (s[i] != u[i])) begin
                term = 1'b1; es = s[i]; eu = u[i]; w = 2'(i);
            end
        end
        if (!term && ab) term = 1'b1;
    endfunction

    task automatic begin_solve(output bit ok);
        ok = 1'b0;
        bus.host_start = 1'b1;
        step();
        bus.host_start = 1'b0;
        for (int n = 0; n < 20 && !ok; n++) begin
            if (bus.core_start) ok = 1'b1;
            else step();
        end
        check("core_start_seen", ok, 1);
        if (ok) begin
            check("cycles_clear_on_solve", bus.host_cycles, 0);
            check("done_clear_on_solve", bus.host_done, 0);
        end
    endtask

    task automatic run_vec(input vec_t v, input int k);
        bit ok;
        int a0;
        begin_solve(ok);
        if (!ok) return;
        a0 = abort_cnt;
        repeat (k) step();
        bus.core_done  = v.done;
        bus.core_sat   = v.sat;
        bus.core_unsat = v.unsat;
        bus.host_abort = v.abort;
        step();
        idle_inputs();
        if (v.term) begin
            check("tbl_done", bus.host_done, 1);
            check("tbl_sat", bus.host_sat, v.e_sat);
            check("tbl_unsat", bus.host_unsat, v.e_unsat);
            check("tbl_winner", bus.host_winner, v.e_win);
            check("tbl_cycles", bus.host_cycles, k);
            check("tbl_timeout", bus.host_timeout, 0);
            step();
            step();
            check("tbl_abort_pulses", abort_cnt - a0, 1);
            check("tbl_winner_hold", bus.host_winner, v.e_win);
            check("tbl_done_hold", bus.host_done, 1);
        end else begin
            check("tbl_not_done", bus.host_done, 0);
            check("tbl_cycles_run", bus.host_cycles, k + 1);
            bus.host_abort = 1'b1;
            step();
            bus.host_abort = 1'b0;
            check("tbl_abort_done", bus.host_done, 1);
            check("tbl_abort_sat", bus.host_sat, 0);
            check("tbl_abort_unsat", bus.host_unsat, 0);
            check("tbl_abort_cycles", bus.host_cycles, k + 1);
            step();
            check("tbl_abort_pulses", abort_cnt - a0, 1);
        end
    endtask

    initial begin
        bit ok;
        bit got;
        bit acc;
        int idx;
        int cyc;
        int k;
        int a0;
        int s0;
        logic term, es, eu;
        logic [1:0] w;
        logic [3:0] d, s, u;
        logic ab;
        logic [32:0] sent[3];

        tbl[0] = '{4'b0110, 4'b0100, 4'b0010, 1'b0, 1'b1, 1'b0, 1'b1, 2'd1};
        tbl[1] = '{4'b0001, 4'b0001, 4'b0001, 1'b1, 1'b1, 1'b0, 1'b0, 2'd0};
        tbl[2] = '{4'b1000, 4'b1000, 4'b0000, 1'b1, 1'b1, 1'b1, 1'b0, 2'd3};
        tbl[3] = '{4'b1111, 4'b1111, 4'b1111, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0};
        tbl[4] = '{4'b0101, 4'b0001, 4'b0100, 1'b0, 1'b1, 1'b1, 1'b0, 2'd0};
        tbl[5] = '{4'b1100, 4'b0000, 4'b1000, 1'b0, 1'b1, 1'b0, 1'b1, 2'd3};
        tbl[6] = '{4'b0000, 4'b0000, 4'b0000, 1'b1, 1'b1, 1'b0, 1'b0, 2'd0};
        tbl[7] = '{4'b0010, 4'b0010, 4'b0000, 1'b0, 1'b1, 1'b1, 1'b0, 2'd1};

        idle_inputs();
        bus.host_timeout_lim = '0;
        #1;
        check("rst_load_ready", bus.host_load_ready, 0);
        check("rst_core_valid", bus.core_load_valid, 0);
        check("rst_done", bus.host_done, 0);
        check("rst_cycles", bus.host_cycles, 0);
        check("rst_core_start", bus.core_start, 0);
        step();
        step();
        rst_n = 1'b1;
        #1;
        check("ready_after_release", bus.host_load_ready, 1);
        step();

        for (int t = 0; t < 8; t++) run_vec(tbl[t], int'($urandom_range(0, 3)));

        // Three-literal stream with two cycles of partial core readiness.
        for (int i = 0; i < 3; i++) sent[i] = {(i == 2), 32'($urandom)};
        delivered.delete();
        idx = 0;
        cyc = 0;
        while (cyc < 40 && (idx < 3 || bus.core_load_valid)) begin
            bus.core_load_ready = (cyc == 1 || cyc == 2) ? 4'b1011 : 4'b1111;
            bus.host_load_valid = (idx < 3);
            if (idx < 3) {bus.host_load_clause_end, bus.host_load_literal} = sent[idx];
            #1;
            acc = bus.host_load_valid && bus.host_load_ready;
            if (cyc == 1 || cyc == 2) begin
                check("ready_low_partial", bus.host_load_ready, 0);
                check("slice_held", bus.core_load_valid, 1);
            end
            step();
            if (cyc == 0) begin
                check("load_clears_done", bus.host_done, 0);
                check("load_clears_cycles", bus.host_cycles, 0);
            end
            if (acc) idx++;
            cyc++;
        end
        idle_inputs();
        step();
        check("stream_count", delivered.size(), 3);
        for (int i = 0; i < 3; i++)
            if (i < delivered.size()) check("stream_word", delivered[i], sent[i]);

        // Start requested while the slice is stuck behind unready cores.
        bus.core_load_ready   = 4'b0000;
        bus.host_load_valid   = 1'b1;
        bus.host_load_literal = -32'sd7;
        step();
        bus.host_load_valid = 1'b0;
        delivered.delete();
        s0 = start_cnt;
        bus.host_start = 1'b1;
        step();
        bus.host_start = 1'b0;
        repeat (3) step();
        check("start_blocked", start_cnt - s0, 0);
        bus.core_load_ready = 4'hF;
        step();
        check("ready_low_pending", bus.host_load_ready, 0);
        check("start_not_yet", bus.core_start, 0);
        step();
        check("start_after_drain", bus.core_start, 1);
        step();
        step();
        check("start_single", start_cnt - s0, 1);
        check("drain_count", delivered.size(), 1);
        bus.host_abort = 1'b1;
        step();
        bus.host_abort = 1'b0;
        step();

`ifdef SWARM_HOST_TIMEOUT_EN
        bus.host_timeout_lim = 10;
        begin_solve(ok);
        got = 1'b0;
        for (int n = 0; n < 40 && !got; n++) begin
            step();
            if (bus.host_done) got = 1'b1;
        end
        check("timeout_reached", got, 1);
        check("timeout_flag", bus.host_timeout, 1);
        check("timeout_cycles", bus.host_cycles, 10);
        check("timeout_sat", bus.host_sat, 0);
        check("timeout_unsat", bus.host_unsat, 0);
        bus.host_timeout_lim = '0;
`else
        bus.host_timeout_lim = 10;
        begin_solve(ok);
        repeat (15) step();
        check("no_timeout_done", bus.host_done, 0);
        check("no_timeout_flag", bus.host_timeout, 0);
        check("no_timeout_cycles", bus.host_cycles, 15);
        bus.host_abort = 1'b1;
        step();
        bus.host_abort = 1'b0;
        check("no_timeout_abort_flag", bus.host_timeout, 0);
        bus.host_timeout_lim = '0;
`endif

        for (int r = 0; r < 25; r++) begin
            begin_solve(ok);
            a0 = abort_cnt;
            k = int'($urandom_range(0, 3));
            repeat (k) step();
            term = 1'b0;
            for (int n = 0; n < 8 && !term; n++) begin
                d  = ($urandom_range(0, 1) == 0) ? 4'b0 : 4'($urandom);
                s  = 4'($urandom);
                u  = 4'($urandom);
                ab = (n == 7) || ($urandom_range(0, 3) == 0);
                ref_model(d, s, u, ab, term, es, eu, w);
                bus.core_done  = d;
                bus.core_sat   = s;
                bus.core_unsat = u;
                bus.host_abort = ab;
                step();
                idle_inputs();
                check("rnd_done", bus.host_done, term);
                if (!term) k++;
            end
            check("rnd_sat", bus.host_sat, es);
            check("rnd_unsat", bus.host_unsat, eu);
            check("rnd_winner", bus.host_winner, w);
            check("rnd_cycles", bus.host_cycles, k);
            step();
            check("rnd_abort_pulses", abort_cnt - a0, 1);
        end

        // Reset in the middle of a solve.
        begin_solve(ok);
        repeat (3) step();
        a0 = abort_cnt;
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_done", bus.host_done, 0);
        check("mid_rst_cycles", bus.host_cycles, 0);
        check("mid_rst_winner", bus.host_winner, 0);
        check("mid_rst_start", bus.core_start, 0);
        check("mid_rst_abort", bus.core_abort, 0);
        check("mid_rst_ready", bus.host_load_ready, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        #1;
        check("mid_rst_ready_release", bus.host_load_ready, 1);
        step();
        step();
        check("mid_rst_no_abort", abort_cnt - a0, 0);
        check("mid_rst_idle_done", bus.host_done, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
